// File: rtl/obuft_bus_arbiter_if.sv
// obuft_bus_arbiter_if
//   Bundles the requester-facing and pad-facing signals of the tri-state
//   bus arbiter.
//   req   : per-requester level-sensitive request
//   din   : per-requester data, requester k in din[k] (same bit layout as
//           a flat N*WIDTH vector sliced at k*WIDTH)
//   hiz   : global release, forces high-Z and blocks new grants
//   gnt   : one-hot grant, zero when nobody owns the bus
//   bus_i : data to the pad buffer I pins
//   bus_t : pad buffer T pins, 1 = high-Z
//   busy  : arbiter not idle
//   master modport = requester side, slave modport = arbiter.
interface obuft_bus_arbiter_if #(
    parameter int N     = 4,
    parameter int WIDTH = 8
);
    logic [N-1:0]            req;
    logic [N-1:0][WIDTH-1:0] din;
    logic                    hiz;
    logic [N-1:0]            gnt;
    logic [WIDTH-1:0]        bus_i;
    logic                    bus_t;
    logic                    busy;

    modport master (output req, din, hiz, input  gnt, bus_i, bus_t, busy);
    modport slave  (input  req, din, hiz, output gnt, bus_i, bus_t, busy);
endinterface

// File: rtl/obuft_bus_arbiter.sv
// obuft_bus_arbiter
//   Round-robin owner selection for a shared OBUFT pad bus. Bounds each
//   grant to MAX_BURST driven cycles and inserts TA_CYCLES of high-Z between
//   owners so two pad drivers never overlap. All outputs are registered.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of obuft_bus_arbiter_if (req/din/hiz in,
//           gnt/bus_i/bus_t/busy out)
module obuft_bus_arbiter #(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter int TA_CYCLES = 1,
    parameter int MAX_BURST = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    obuft_bus_arbiter_if.slave bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, TURN} state_t;

    state_t           state, state_nxt;
    logic [PW-1:0]    ptr, ptr_nxt;
    logic [7:0]       burst_cnt, burst_cnt_nxt;
    logic [2:0]       turn_cnt, turn_cnt_nxt;
    logic [N-1:0]     gnt_q, gnt_nxt;
    logic [WIDTH-1:0] bus_i_q, bus_i_nxt;
    logic             bus_t_q, busy_q;

    logic             win_vld;
    logic [PW-1:0]    win_idx;
    logic [PW-1:0]    cand;

    // First requester strictly after ptr, wrapping. ptr itself is tried
    // last, so an owner cut off by MAX_BURST only wins again when alone.
    always_comb begin
        win_vld = 1'b0;
        win_idx = ptr;
        cand    = '0;
        for (int i = 1; i <= N; i++) begin
            cand = PW'((int'(ptr) + i) % N);
            if (!win_vld && bus.req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        ptr_nxt       = ptr;
        burst_cnt_nxt = burst_cnt;
        turn_cnt_nxt  = turn_cnt;
        gnt_nxt       = '0;
        bus_i_nxt     = bus_i_q;
        case (state)
            IDLE: begin
                if (!bus.hiz && win_vld) begin
                    state_nxt        = DRIVE;
                    gnt_nxt[win_idx] = 1'b1;
                    ptr_nxt          = win_idx;
                    burst_cnt_nxt    = 8'd1;
                    bus_i_nxt        = bus.din[win_idx];
                end
            end
            DRIVE: begin
                // ptr is the current owner while driving
                if (bus.req[ptr] && !bus.hiz && burst_cnt < 8'(MAX_BURST)) begin
                    gnt_nxt       = gnt_q;
                    burst_cnt_nxt = burst_cnt + 8'd1;
                    bus_i_nxt     = bus.din[ptr];
                end else begin
                    state_nxt     = TURN;
                    burst_cnt_nxt = '0;
                    turn_cnt_nxt  = 3'(TA_CYCLES);
                end
            end
            TURN: begin
                // Loaded with TA_CYCLES on entry; deciding at 1 yields
                // exactly TA_CYCLES high-Z cycles before the next owner.
                if (turn_cnt <= 3'd1) begin
                    turn_cnt_nxt = '0;
                    if (!bus.hiz && win_vld) begin
                        state_nxt        = DRIVE;
                        gnt_nxt[win_idx] = 1'b1;
                        ptr_nxt          = win_idx;
                        burst_cnt_nxt    = 8'd1;
                        bus_i_nxt        = bus.din[win_idx];
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    turn_cnt_nxt = turn_cnt - 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= PW'(N - 1);
            burst_cnt <= '0;
            turn_cnt  <= '0;
            gnt_q     <= '0;
            bus_i_q   <= '0;
            bus_t_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            ptr       <= ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
            turn_cnt  <= turn_cnt_nxt;
            gnt_q     <= gnt_nxt;
            bus_i_q   <= bus_i_nxt;
            // derived from the same next value so T can never disagree with GNT
            bus_t_q   <= ~|gnt_nxt;
            busy_q    <= (state_nxt != IDLE);
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.bus_i = bus_i_q;
    assign bus.bus_t = bus_t_q;
    assign bus.busy  = busy_q;
endmodule

// File: tb/tb_obuft_bus_arbiter.sv
// Bench for obuft_bus_arbiter. Three instances share one stimulus:
//   u_a : TA_CYCLES=1, MAX_BURST=2
//   u_b : TA_CYCLES=1, MAX_BURST=16
//   u_c : TA_CYCLES=3, MAX_BURST=16
// A behavioural model tracks owner, driven-run length and high-Z run length
// per instance and is compared every cycle; directed sections add literal
// expectations.
module tb_obuft_bus_arbiter;
    localparam int NI = 3;
    localparam int TA_P [NI] = '{1, 1, 3};
    localparam int MB_P [NI] = '{2, 16, 16};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0]      req = '0;
    logic [3:0][7:0] din = '0;
    logic            hiz = 1'b0;

    always #5 clk = ~clk;

    obuft_bus_arbiter_if #(.N(4), .WIDTH(8)) ifa ();
    obuft_bus_arbiter_if #(.N(4), .WIDTH(8)) ifb ();
    obuft_bus_arbiter_if #(.N(4), .WIDTH(8)) ifc ();

    assign ifa.req = req; assign ifa.din = din; assign ifa.hiz = hiz;
    assign ifb.req = req; assign ifb.din = din; assign ifb.hiz = hiz;
    assign ifc.req = req; assign ifc.din = din; assign ifc.hiz = hiz;

    obuft_bus_arbiter #(.N(4), .WIDTH(8), .TA_CYCLES(1), .MAX_BURST(2))
        u_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    obuft_bus_arbiter #(.N(4), .WIDTH(8), .TA_CYCLES(1), .MAX_BURST(16))
        u_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
    obuft_bus_arbiter #(.N(4), .WIDTH(8), .TA_CYCLES(3), .MAX_BURST(16))
        u_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

    logic [3:0] g  [NI];
    logic [7:0] bi [NI];
    logic       bt [NI];
    logic       bz [NI];
    assign g[0] = ifa.gnt; assign bi[0] = ifa.bus_i; assign bt[0] = ifa.bus_t; assign bz[0] = ifa.busy;
    assign g[1] = ifb.gnt; assign bi[1] = ifb.bus_i; assign bt[1] = ifb.bus_t; assign bz[1] = ifb.busy;
    assign g[2] = ifc.gnt; assign bi[2] = ifc.bus_i; assign bt[2] = ifc.bus_t; assign bz[2] = ifc.busy;

    int total = 0;
    int bad   = 0;
    logic run_chk = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: own = current owner (-1 none), run = driven cycles so far in
    // this grant, hz = consecutive high-Z cycles since the last driven one,
    // last = most recently granted requester.
    int         own  [NI];
    int         run  [NI];
    int         hz   [NI];
    int         last [NI];
    logic [7:0] mbi  [NI];

    always @(posedge clk or negedge rst_n) begin
        int  c;
        bit  found;
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                own[i] = -1; run[i] = 0; hz[i] = TA_P[i] + 1; last[i] = 3; mbi[i] = 8'h00;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (own[i] >= 0) begin
                    if (req[own[i]] && !hiz && run[i] < MB_P[i]) begin
                        run[i]++;
                        mbi[i] = din[own[i]];
                    end else begin
                        own[i] = -1;
                        hz[i]  = 1;
                    end
                end else if (hz[i] >= TA_P[i] && !hiz && req != 4'b0) begin
                    found = 1'b0;
                    for (int j = 1; j <= 4; j++) begin
                        c = (last[i] + j) % 4;
                        if (!found && req[c]) begin
                            found   = 1'b1;
                            own[i]  = c;
                            last[i] = c;
                        end
                    end
                    run[i] = 1;
                    mbi[i] = din[own[i]];
                end else if (hz[i] < 1000) begin
                    hz[i]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] eg;
        if (run_chk) begin
            for (int i = 0; i < NI; i++) begin
                eg = (own[i] >= 0) ? 4'(1 << own[i]) : 4'b0000;
                chk($sformatf("gnt[%0d]", i),   32'(g[i]),  32'(eg));
                chk($sformatf("bus_t[%0d]", i), 32'(bt[i]), 32'(own[i] < 0));
                chk($sformatf("bus_i[%0d]", i), 32'(bi[i]), 32'(mbi[i]));
                chk($sformatf("busy[%0d]", i),  32'(bz[i]), 32'(own[i] >= 0 || hz[i] <= TA_P[i]));
                chk($sformatf("onehot[%0d]", i), 32'($onehot0(g[i])), 32'd1);
                chk($sformatf("t_inv[%0d]", i),  32'(bt[i]), 32'(~|g[i]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req   = '0;
        hiz   = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [3:0] fair_exp [13] = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0,
                                  4'h8, 4'h8, 4'h0, 4'h1};

    initial begin
        do_reset();
        run_chk = 1'b1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_gnt", 32'(g[i]), 32'h0);
            chk("rst_busy", 32'(bz[i]), 32'h0);
            chk("rst_t", 32'(bt[i]), 32'h1);
        end

        // asynchronous reset in the middle of a grant to requester 1
        din[1] = 8'h3C;
        req = 4'b0010;
        tick();
        chk("pre_rst_gnt", 32'(g[1]), 32'h2);
        chk("pre_rst_bi", 32'(bi[1]), 32'h3C);
        #3 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("arst_gnt", 32'(g[i]), 32'h0);
            chk("arst_t", 32'(bt[i]), 32'h1);
            chk("arst_bi", 32'(bi[i]), 32'h0);
            chk("arst_busy", 32'(bz[i]), 32'h0);
        end
        #2 rst_n = 1'b1;
        req = 4'b1111;
        tick();
        for (int i = 0; i < NI; i++) chk("post_rst_first", 32'(g[i]), 32'h1);

        // fairness on u_a: MAX_BURST=2, TA=1
        do_reset();
        req = 4'b1111;
        for (int t = 0; t < 13; t++) begin
            tick();
            chk($sformatf("fair_%0d", t), 32'(g[0]), 32'(fair_exp[t]));
        end

        // single requester on u_b
        do_reset();
        din[0] = 8'hA5;
        req = 4'b0001;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk("single_gnt", 32'(g[1]), 32'h1);
            chk("single_bi", 32'(bi[1]), 32'hA5);
            chk("single_t", 32'(bt[1]), 32'h0);
        end
        req = 4'b0000;
        tick();
        chk("single_gap_t", 32'(bt[1]), 32'h1);
        chk("single_gap_busy", 32'(bz[1]), 32'h1);
        tick();
        chk("single_idle_busy", 32'(bz[1]), 32'h0);
        chk("single_idle_t", 32'(bt[1]), 32'h1);

        // handoff on u_c: TA=3
        do_reset();
        din[0] = 8'h11;
        din[2] = 8'h5A;
        req = 4'b0001;
        tick();
        chk("ho_first", 32'(g[2]), 32'h1);
        tick();
        req = 4'b0100;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk($sformatf("ho_gap_%0d", t), 32'(bt[2]), 32'h1);
        end
        tick();
        chk("ho_gnt", 32'(g[2]), 32'h4);
        chk("ho_bi", 32'(bi[2]), 32'h5A);
        chk("ho_t", 32'(bt[2]), 32'h0);

        // hiz mid-burst on u_b
        do_reset();
        req = 4'b0001;
        tick();
        chk("hiz_pre", 32'(g[1]), 32'h1);
        hiz = 1'b1;
        req = 4'b0011;
        tick();
        chk("hiz_t", 32'(bt[1]), 32'h1);
        tick();
        chk("hiz_block0", 32'(g[1]), 32'h0);
        tick();
        chk("hiz_block1", 32'(g[1]), 32'h0);
        hiz = 1'b0;
        tick();
        chk("hiz_after", 32'(g[1]), 32'h2);

        // random traffic, checked every cycle by the model compare
        do_reset();
        for (int t = 0; t < 10000; t++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom);
            hiz = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < 4; k++) din[k] = 8'($urandom);
            tick();
        end

        run_chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
